// File: rtl/hls_datapath_host_if.sv
// hls_datapath_host_if
//   Bundles the three channels of the HLS datapath host:
//     - operand input channel  : in_valid / in_ready / in_a / in_b / in_c
//     - datapath drive/capture : dp_a / dp_b / dp_c (to datapath), dp_z / dp_x (from datapath)
//     - result output channel  : out_valid / out_ready / out_z / out_x
//     - status                 : inflight (accepted triples whose results are not yet buffered)
//   modport slave  : the host itself (accepts operands, drives the datapath, offers results)
//   modport master : the environment (operand producer, datapath, result consumer)
interface hls_datapath_host_if #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) ();
  localparam int HW = DW / 2;
  localparam int IW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] in_c;
  logic [DW-1:0] dp_a;
  logic [DW-1:0] dp_b;
  logic [DW-1:0] dp_c;
  logic [HW-1:0] dp_z;
  logic [HW-1:0] dp_x;
  logic          out_valid;
  logic          out_ready;
  logic [HW-1:0] out_z;
  logic [HW-1:0] out_x;
  logic [IW-1:0] inflight;

  modport master (
    output in_valid, in_a, in_b, in_c, dp_z, dp_x, out_ready,
    input  in_ready, dp_a, dp_b, dp_c, out_valid, out_z, out_x, inflight
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, dp_z, dp_x, out_ready,
    output in_ready, dp_a, dp_b, dp_c, out_valid, out_z, out_x, inflight
  );
endinterface

// File: rtl/hls_datapath_host.sv
// hls_datapath_host
//   Host-side sequencer for a fixed-latency HLS datapath. Operand triples
//   accepted on the input channel are registered onto dp_a/dp_b/dp_c; a
//   LAT+1 deep valid pipeline marks the edge at which the datapath result is
//   stable, where {dp_z, dp_x} is written into a DEPTH-entry result FIFO.
//   Results leave in order on the output channel. Admission is credit based:
//   a triple is only accepted while inflight + fifo_count < DEPTH, so the FIFO
//   can never overflow.
// Ports
//   Clk : clock, rising edge
//   Rst : synchronous active-high reset (shared with the attached datapath)
//   bus : hls_datapath_host_if.slave (input channel, datapath ports,
//         output channel, inflight status)
module hls_datapath_host #(
  parameter int DW    = 64,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hls_datapath_host_if.slave    bus
);
  localparam int HW = DW / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [DW-1:0] dp_a_r;
  logic [DW-1:0] dp_b_r;
  logic [DW-1:0] dp_c_r;
  logic [LAT:0]  vpipe_r;
  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] inflight_r;

  logic [CW-1:0] occ_s;
  logic          in_ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          out_valid_s;

  // Credit check and handshake strobes; in_ready depends only on state and Rst.
  always_comb begin
    occ_s       = inflight_r + count_r;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    if (Rst) begin
      in_ready_s = 1'b0;
    end else if (occ_s < CNT_MAX) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    if (count_r != CNT_ZERO) begin
      out_valid_s = 1'b1;
    end else begin
      out_valid_s = 1'b0;
    end
    accept_s = bus.in_valid && in_ready_s;
    push_s   = vpipe_r[LAT];
    pop_s    = out_valid_s && bus.out_ready;
  end

  // Operand registers driving the datapath; hold their value between accepts.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      dp_a_r <= {DW{1'b0}};
      dp_b_r <= {DW{1'b0}};
      dp_c_r <= {DW{1'b0}};
    end else if (accept_s) begin
      dp_a_r <= bus.in_a;
      dp_b_r <= bus.in_b;
      dp_c_r <= bus.in_c;
    end else begin
      dp_a_r <= dp_a_r;
      dp_b_r <= dp_b_r;
      dp_c_r <= dp_c_r;
    end
  end

  // Valid pipeline: an accept at edge k reaches the top bit after edge k+LAT,
  // so the push happens at edge k+LAT+1 when the datapath output is settled.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vpipe_r <= {(LAT+1){1'b0}};
    end else begin
      vpipe_r <= {vpipe_r[LAT-1:0], accept_s};
    end
  end

  // Result storage and circular pointers; power-of-two DEPTH makes wrap free.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {bus.dp_z, bus.dp_x};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO occupancy; simultaneous push and pop leaves it unchanged at any level.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Triples accepted but not yet pushed; a result leaving the pipe while a new
  // triple enters cancels out.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      inflight_r <= CNT_ZERO;
    end else begin
      case ({accept_s, push_s})
        2'b10:   inflight_r <= inflight_r + CNT_ONE;
        2'b01:   inflight_r <= inflight_r - CNT_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.dp_a      = dp_a_r;
  assign bus.dp_b      = dp_b_r;
  assign bus.dp_c      = dp_c_r;
  assign bus.out_valid = out_valid_s;
  assign bus.out_z     = mem_r[rd_ptr_r][DW-1:HW];
  assign bus.out_x     = mem_r[rd_ptr_r][HW-1:0];
  assign bus.inflight  = inflight_r;

endmodule

// File: tb/tb_hls_datapath_host.sv
// tb_hls_datapath_host
//   Directed vector table plus hand-written multi-cycle sequences for
//   hls_datapath_host, with a reference datapath (z = a+b, x = c, LAT register
//   stages) and a cycle-level scoreboard of credits, pipeline and FIFO order.
module tb_hls_datapath_host;
  localparam int DW    = 64;
  localparam int HW    = DW / 2;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  hls_datapath_host_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  hls_datapath_host #(.DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference datapath: LAT register stages, reset with the host.
  logic [HW-1:0] zp_r [LAT];
  logic [HW-1:0] xp_r [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        zp_r[i] <= '0;
        xp_r[i] <= '0;
      end
    end else begin
      zp_r[0] <= bus.dp_a[HW-1:0] + bus.dp_b[HW-1:0];
      xp_r[0] <= bus.dp_c[HW-1:0];
      for (int i = 1; i < LAT; i++) begin
        zp_r[i] <= zp_r[i-1];
        xp_r[i] <= xp_r[i-1];
      end
    end
  end
  assign bus.dp_z = zp_r[LAT-1];
  assign bus.dp_x = xp_r[LAT-1];

  int n_vec  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard model, updated at every rising edge from pre-edge values.
  logic [63:0] exp_q [$];
  logic [LAT:0] mpipe;
  int minfl;
  int mcount;

  initial begin
    logic [DW-1:0] sum;
    logic          acc;
    logic          pop;
    logic          push;
    mpipe  = '0;
    minfl  = 0;
    mcount = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        check("in_ready_during_reset", {63'd0, bus.in_ready}, 64'd0);
        exp_q.delete();
        mpipe  = '0;
        minfl  = 0;
        mcount = 0;
      end else begin
        check("mon_in_ready", {63'd0, bus.in_ready}, {63'd0, (minfl + mcount) < DEPTH});
        check("mon_out_valid", {63'd0, bus.out_valid}, {63'd0, mcount != 0});
        check("mon_inflight", 64'(bus.inflight), 64'(minfl));
        acc  = bus.in_valid && bus.in_ready;
        pop  = bus.out_valid && bus.out_ready;
        push = mpipe[LAT];
        check("no_overflow", {63'd0, push && !pop && (mcount == DEPTH)}, 64'd0);
        if (pop) begin
          check("pop_has_expected", {63'd0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            check("result_order", {bus.out_z, bus.out_x}, exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
        if (acc) begin
          sum = bus.in_a + bus.in_b;
          exp_q.push_back({sum[HW-1:0], bus.in_c[HW-1:0]});
          n_acc++;
        end
        mpipe  = {mpipe[LAT-1:0], acc};
        minfl  = minfl + int'(acc) - int'(push);
        mcount = mcount + int'(push) - int'(pop);
        check("occupancy_bound", {63'd0, (minfl + mcount) <= DEPTH}, 64'd1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [HW-1:0] ez;
    logic [HW-1:0] ex;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base;
    int ridx;
    int budget;

    vecs[0] = '{64'd10, 64'd3, 64'd2, 32'd13, 32'd2};
    vecs[1] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 64'd7, 32'd0, 32'd7};
    vecs[2] = '{64'h0000_0001_0000_0005, 64'h0000_0002_0000_0003, 64'hABCD_0000_0000_1234, 32'd8, 32'h0000_1234};
    vecs[3] = '{64'd0, 64'd0, 64'd0, 32'd0, 32'd0};
    vecs[4] = '{64'h7FFF_FFFF, 64'h7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    vecs[5] = '{64'hDEAD_BEEF_1234_5678, 64'h1111_1111_0000_0001, 64'hDEAD_BEEF_0000_0005, 32'h1234_5679, 32'd5};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_inflight", 64'(bus.inflight), 64'd0);
    check("rst_dp_a", bus.dp_a, 64'd0);
    check("rst_dp_c", bus.dp_c, 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

    // Single triples from the table: latency, truncation and dp_* hold.
    for (int e = 0; e < 6; e++) begin
      check("vec_idle_ready", {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid  = 1'b1;
      bus.in_a      = vecs[e].a;
      bus.in_b      = vecs[e].b;
      bus.in_c      = vecs[e].c;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      check("vec_dp_a", bus.dp_a, vecs[e].a);
      check("vec_dp_c", bus.dp_c, vecs[e].c);
      for (int k = 0; k < 3; k++) begin
        check("vec_inflight", 64'(bus.inflight), 64'd1);
        check("vec_not_valid_early", {63'd0, bus.out_valid}, 64'd0);
        if (k < 2) tick();
      end
      check("vec_dp_a_hold", bus.dp_a, vecs[e].a);
      tick();
      check("vec_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("vec_out_z", 64'(bus.out_z), 64'(vecs[e].ez));
      check("vec_out_x", 64'(bus.out_x), 64'(vecs[e].ex));
      check("vec_inflight_done", 64'(bus.inflight), 64'd0);
      tick();
      check("vec_popped", {63'd0, bus.out_valid}, 64'd0);
    end

    // Back-to-back stream of eight triples with out_ready held high.
    base = 0;
    ridx = 0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 60 && ridx < 8; t++) begin
      if (base < 8) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 64'(base);
        bus.in_b     = 64'd100;
        bus.in_c     = 64'(base);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        check("b2b_z", 64'(bus.out_z), 64'(100 + ridx));
        check("b2b_x", 64'(bus.out_x), 64'(ridx));
        ridx++;
      end
      if (bus.in_valid && bus.in_ready) base++;
      tick();
    end
    check("b2b_all_results", 64'(ridx), 64'd8);
    bus.in_valid = 1'b0;
    tick();

    // Credit exhaustion with out_ready low, then one pop releases one credit.
    base = n_acc;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int t = 0; t < 7; t++) begin
      bus.in_a = 64'(1000 + t);
      bus.in_b = 64'(t);
      bus.in_c = 64'(t);
      tick();
    end
    check("fill_accepts", 64'(n_acc - base), 64'd4);
    check("fill_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    check("fill_inflight", 64'(bus.inflight), 64'd0);
    check("fill_out_valid", {63'd0, bus.out_valid}, 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("credit_back", {63'd0, bus.in_ready}, 64'd1);
    tick();
    check("credit_used", {63'd0, bus.in_ready}, 64'd0);
    check("one_more_accept", 64'(n_acc - base), 64'd5);

    // Near-full operation: pop only when full or when a push is due.
    for (int t = 0; t < 60; t++) begin
      bus.in_valid  = 1'b1;
      bus.in_a      = 64'(2000 + t);
      bus.in_b      = 64'(3 * t);
      bus.in_c      = 64'(t);
      bus.out_ready = (mcount == DEPTH) || mpipe[LAT];
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    check("drain_empty", {63'd0, bus.out_valid}, 64'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);

    // Reset with two results in flight and two buffered.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int t = 0; t < 5; t++) begin
      bus.in_a = 64'(500 + t);
      bus.in_b = 64'd7;
      bus.in_c = 64'(77 + t);
      tick();
    end
    check("pre_reset_inflight", 64'(bus.inflight), 64'd2);
    check("pre_reset_out_valid", {63'd0, bus.out_valid}, 64'd1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_inflight", 64'(bus.inflight), 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      check("no_stale_result", {63'd0, bus.out_valid}, 64'd0);
    end
    bus.in_valid = 1'b1;
    bus.in_a     = 64'd1;
    bus.in_b     = 64'd1;
    bus.in_c     = 64'd5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("post_rst_valid", {63'd0, bus.out_valid}, 64'd1);
    check("post_rst_z", 64'(bus.out_z), 64'd2);
    check("post_rst_x", 64'(bus.out_x), 64'd5);
    tick();

    // Random handshakes for 1000 triples against the scoreboard.
    base   = n_acc;
    budget = 0;
    while ((n_acc - base) < 1000 && budget < 20000) begin
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.out_ready = $urandom_range(0, 1) == 1;
      bus.in_a      = {$urandom, $urandom};
      bus.in_b      = {$urandom, $urandom};
      bus.in_c      = {$urandom, $urandom};
      tick();
      budget++;
    end
    check("random_accepts", 64'(n_acc - base), 64'd1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    check("random_drained", {63'd0, bus.out_valid}, 64'd0);
    check("random_queue_empty", 64'(exp_q.size()), 64'd0);
    check("random_inflight", 64'(bus.inflight), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
